// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry, pointer-width helper and the
// per-cycle operation encoding used by the FIFO controller.
package fifo_pkg;

    localparam int FIFO_WIDTH_DEF = 8;
    localparam int FIFO_DEPTH_DEF = 8;

    // Encoding is {write_accepted, read_accepted}
    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_BOTH  = 2'b11
    } fifo_op_e;

    function automatic int fifo_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_param_ram.sv
// Simple dual-port storage for fifo_param: synchronous write, registered read.
// The array itself is never reset; only the read-data register is.
module fifo_param_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-before-write on an address collision, so a read of a full FIFO
    // with a concurrent write returns the oldest word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with occupancy-based flags and read-valid strobe.
// Define FIFO_PARAM_STICKY_ERR_EN to make error latch until reset.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH  = FIFO_WIDTH_DEF,
    parameter int DEPTH  = FIFO_DEPTH_DEF,
    parameter int AF_LVL = DEPTH - 1,
    parameter int AE_LVL = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wen,
    input  logic                     ren,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    output logic                     error,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [fifo_aw(DEPTH):0]  count
);

    localparam int AW = fifo_aw(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];
    localparam logic [AW:0] AF_CNT    = AF_LVL[AW:0];
    localparam logic [AW:0] AE_CNT    = AE_LVL[AW:0];

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [AW:0]   count_reg, count_next;
    logic          valid_reg;
    logic          error_reg, error_next;
    logic          wr_acc, rd_acc, illegal;
    fifo_op_e      op;

    assign full         = (count_reg == DEPTH_CNT);
    assign empty        = (count_reg == '0);
    assign almost_full  = (count_reg >= AF_CNT);
    assign almost_empty = (count_reg <= AE_CNT);
    assign count        = count_reg;
    assign valid        = valid_reg;
    assign error        = error_reg;

    always_comb begin
        // A write into a full FIFO is fine when a read frees the slot this cycle.
        wr_acc  = wen && (!full || ren);
        rd_acc  = ren && !empty;
        illegal = (ren && empty) || (wen && full && !ren);
        op      = fifo_op_e'({wr_acc, rd_acc});

        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;

        if (wr_acc) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end

        case (op)
            OP_WRITE: count_next = count_reg + 1'b1;
            OP_READ:  count_next = count_reg - 1'b1;
            default:  count_next = count_reg;
        endcase

`ifdef FIFO_PARAM_STICKY_ERR_EN
        error_next = error_reg | illegal;
`else
        error_next = illegal;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            valid_reg  <= 1'b0;
            error_reg  <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            valid_reg  <= rd_acc;
            error_reg  <= error_next;
        end
    end

    fifo_param_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wr_ptr_reg),
        .wdata (din),
        .re    (rd_acc),
        .raddr (rd_ptr_reg),
        .rdata (dout)
    );

endmodule

// File: tb/tb_fifo_param.sv
// Directed self-checking bench for fifo_param (WIDTH=8, DEPTH=8, AF_LVL=6, AE_LVL=2).
module tb_fifo_param;
    import fifo_pkg::*;

    localparam int W  = FIFO_WIDTH_DEF;
    localparam int D  = FIFO_DEPTH_DEF;
    localparam int AW = fifo_aw(D);
    localparam int AF = 6;
    localparam int AE = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          wen, ren;
    logic [W-1:0]  din;
    logic [W-1:0]  dout;
    logic          valid, error, full, empty, almost_full, almost_empty;
    logic [AW:0]   count;

    int vectors     = 0;
    int miscompares = 0;

    fifo_param #(
        .WIDTH  (W),
        .DEPTH  (D),
        .AF_LVL (AF),
        .AE_LVL (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wen          (wen),
        .ren          (ren),
        .din          (din),
        .dout         (dout),
        .valid        (valid),
        .error        (error),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int ecnt, input logic evalid,
                           input logic [7:0] edout, input logic eerr);
        chk({tag, "/count"}, 32'(count), 32'(ecnt));
        chk({tag, "/full"},  32'(full),  32'(ecnt == D));
        chk({tag, "/empty"}, 32'(empty), 32'(ecnt == 0));
        chk({tag, "/afull"}, 32'(almost_full),  32'(ecnt >= AF));
        chk({tag, "/aempty"},32'(almost_empty), 32'(ecnt <= AE));
        chk({tag, "/valid"}, 32'(valid), 32'(evalid));
        chk({tag, "/dout"},  32'(dout),  32'(edout));
        chk({tag, "/error"}, 32'(error), 32'(eerr));
        $display("%-12s wen=%0b ren=%0b count=%0d valid=%0b dout=%02h error=%0b",
                 tag, wen, ren, count, valid, dout, error);
    endtask

    task automatic step(input string tag, input logic w, input logic r, input logic [7:0] d,
                        input int ecnt, input logic evalid, input logic [7:0] edout,
                        input logic eerr);
        wen = w;
        ren = r;
        din = d;
        @(posedge clk);
        #1;
        chk_out(tag, ecnt, evalid, edout, eerr);
        wen = 1'b0;
        ren = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] last;
        int cnt, wi, ri;

        rst = 1'b1;
        wen = 1'b0;
        ren = 1'b0;
        din = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_out("reset", 0, 1'b0, 8'h00, 1'b0);

        // Read of an empty FIFO: one-cycle error, nothing else moves
        step("rd_empty", 1'b0, 1'b1, 8'h00, 0, 1'b0, 8'h00, 1'b1);
        step("idle",     1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h00, 1'b0);

        // Fill with 0x00, 0x11 .. 0x77 (all-zero word is legal data)
        for (int i = 0; i < 8; i++)
            step("fill", 1'b1, 1'b0, 8'(i * 17), i + 1, 1'b0, 8'h00, 1'b0);
        step("wr_full",   1'b1, 1'b0, 8'h99, 8, 1'b0, 8'h00, 1'b1);
        step("idle_full", 1'b0, 1'b0, 8'h00, 8, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++)
            step("drain", 1'b0, 1'b1, 8'h00, 7 - i, 1'b1, 8'(i * 17), 1'b0);
        step("idle_empty", 1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h77, 1'b0);

        // Full FIFO, simultaneous write and read
        for (int i = 0; i < 8; i++)
            step("fill2", 1'b1, 1'b0, 8'(8'hA0 + i), i + 1, 1'b0, 8'h77, 1'b0);
        step("full_wr_rd", 1'b1, 1'b1, 8'hAB, 8, 1'b1, 8'hA0, 1'b0);
        for (int i = 1; i < 8; i++)
            step("drain2", 1'b0, 1'b1, 8'h00, 8 - i, 1'b1, 8'(8'hA0 + i), 1'b0);
        step("drain2_ab", 1'b0, 1'b1, 8'h00, 0, 1'b1, 8'hAB, 1'b0);

        // Empty FIFO, simultaneous write and read: no fall-through
        step("empty_wr_rd", 1'b1, 1'b1, 8'h5A, 1, 1'b0, 8'hAB, 1'b1);
        step("rd_5a",       1'b0, 1'b1, 8'h00, 0, 1'b1, 8'h5A, 1'b0);

        // Wrap: fill to 7, then 20 alternating single reads/writes, then drain
        last = 8'h5A;
        for (int k = 0; k < 7; k++)
            step("wrap_fill", 1'b1, 1'b0, 8'(8'h30 + k), k + 1, 1'b0, last, 1'b0);
        cnt = 7;
        wi  = 7;
        ri  = 0;
        for (int j = 0; j < 20; j++) begin
            if ((j % 2) == 0) begin
                cnt--;
                last = 8'(8'h30 + ri);
                ri++;
                step("wrap_rd", 1'b0, 1'b1, 8'h00, cnt, 1'b1, last, 1'b0);
            end else begin
                cnt++;
                step("wrap_wr", 1'b1, 1'b0, 8'(8'h30 + wi), cnt, 1'b0, last, 1'b0);
                wi++;
            end
        end
        while (cnt > 0) begin
            cnt--;
            last = 8'(8'h30 + ri);
            ri++;
            step("wrap_drain", 1'b0, 1'b1, 8'h00, cnt, 1'b1, last, 1'b0);
        end

        // Asynchronous reset between edges at count 5
        for (int k = 0; k < 6; k++)
            step("pre_rst", 1'b1, 1'b0, 8'(8'hE0 + k), k + 1, 1'b0, last, 1'b0);
        step("pre_rst_rd", 1'b0, 1'b1, 8'h00, 5, 1'b1, 8'hE0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk_out("async_rst", 0, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step("post_wr", 1'b1, 1'b0, 8'hC3, 1, 1'b0, 8'h00, 1'b0);
        step("post_rd", 1'b0, 1'b1, 8'h00, 0, 1'b1, 8'hC3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
